// File: rtl/tcp_rx.sv
`default_nettype none
// ============================================================================
// Module   : tcp_rx
// Purpose  : Receive-side TCP engine for one connection with fixed-size
//            payloads. It accepts a whole segment, optionally verifies the
//            checksum (one 16-bit word per cycle), then decides how the
//            segment affects the connection: deliver payload, ask the
//            transmitter for an ACK / SYN-ACK, change connection state or
//            drop the segment.
// Config   : `define TCP_RX_CSUM_EN enables the per-word checksum CHECK
//            state. When it is undefined the checksum is assumed good and
//            the decision is made on the cycle after capture.
// Ports    : clk, rst_n (async, active low)
//            seg_valid/seg_ready/rx_tcp_data : segment input handshake
//            close_req                       : application close pulse
//            fix_valid/fix_data              : delivered payload (pulse)
//            ack_valid/ack_num/ack_flags     : reply request (pulse)
//            conn_state                      : LISTEN/SYN_RCVD/EST/CLOSE_WAIT
//            drop                            : segment discarded (pulse)
// Revision : 1.0 - initial release
// ============================================================================
module tcp_rx #(
  parameter int unsigned PAYLOAD_LEN = 262,
  parameter int unsigned TCPH_LEN    = 20,
  parameter logic [7:0]  PROTOCOL    = 8'd6,
  parameter logic [31:0] SRCADDR     = 32'h7f000001,
  parameter logic [31:0] DESADDR     = 32'h7f000001,
  parameter logic [15:0] LOCAL_PORT  = 16'd9000
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  seg_valid,
  output logic                                  seg_ready,
  input  logic [(PAYLOAD_LEN+TCPH_LEN)*8-1:0]   rx_tcp_data,
  input  logic                                  close_req,
  output logic                                  fix_valid,
  output logic [PAYLOAD_LEN*8-1:0]              fix_data,
  output logic                                  ack_valid,
  output logic [31:0]                           ack_num,
  output logic [5:0]                            ack_flags,
  output logic [1:0]                            conn_state,
  output logic                                  drop
);

  localparam int unsigned SEG_W  = (PAYLOAD_LEN + TCPH_LEN) * 8;
  localparam int unsigned NWORDS = (PAYLOAD_LEN + TCPH_LEN + 12) / 2;
  localparam int unsigned IDX_W  = $clog2(NWORDS);
  localparam logic [95:0] PSEUDO_HDR =
      {16'(TCPH_LEN + PAYLOAD_LEN), PROTOCOL, 8'h00, DESADDR, SRCADDR};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_DECIDE = 2'd2
  } proc_e;

  typedef enum logic [1:0] {
    LISTEN      = 2'd0,
    SYN_RCVD    = 2'd1,
    ESTABLISHED = 2'd2,
    CLOSE_WAIT  = 2'd3
  } conn_e;

  proc_e                    proc_q, proc_d;
  conn_e                    conn_q, conn_d;
  logic [31:0]              rcv_nxt_q, rcv_nxt_d;
  logic [SEG_W-1:0]         data_q, data_d;
  logic                     seg_ready_q, seg_ready_d;
  logic                     fix_valid_q, fix_valid_d;
  logic [PAYLOAD_LEN*8-1:0] fix_data_q, fix_data_d;
  logic                     ack_valid_q, ack_valid_d;
  logic [31:0]              ack_num_q, ack_num_d;
  logic [5:0]               ack_flags_q, ack_flags_d;
  logic                     drop_q, drop_d;
  logic [31:0]              rcv_adv;

  // Field views of the captured segment
  logic [15:0] w_dport;
  logic [31:0] w_seq;
  logic [3:0]  w_hlen;
  logic        w_fin, w_syn, w_rst, w_psh, w_ack;
  logic        w_csum_ok;
  logic        w_hdr_ok;

  assign w_dport = data_q[31:16];
  assign w_seq   = data_q[63:32];
  assign w_hlen  = data_q[99:96];
  assign w_fin   = data_q[106];
  assign w_syn   = data_q[107];
  assign w_rst   = data_q[108];
  assign w_psh   = data_q[109];
  assign w_ack   = data_q[110];
  assign w_hdr_ok = w_csum_ok && (w_dport == LOCAL_PORT) &&
                    (w_hlen == 4'(TCPH_LEN / 4));

`ifdef TCP_RX_CSUM_EN
  logic [15:0]            sum_q, sum_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NWORDS*16-1:0]   w_csum_vec;
  logic [15:0]            w_word;
  logic [16:0]            w_sum17;

  assign w_csum_vec = {data_q, PSEUDO_HDR};
  assign w_word     = w_csum_vec[idx_q*16 +: 16];
  assign w_sum17    = {1'b0, sum_q} + {1'b0, w_word};
  assign w_csum_ok  = (sum_q == 16'hFFFF);
`else
  // Fields that only feed the checksum are intentionally unused here.
  logic unused_csum;
  assign unused_csum = ^{PSEUDO_HDR, data_q[159:111], data_q[105:100],
                         data_q[95:64], data_q[15:0]};
  assign w_csum_ok   = 1'b1;
`endif

  always_comb begin
    proc_d      = proc_q;
    conn_d      = conn_q;
    rcv_nxt_d   = rcv_nxt_q;
    data_d      = data_q;
    fix_valid_d = 1'b0;
    fix_data_d  = fix_data_q;
    ack_valid_d = 1'b0;
    ack_num_d   = ack_num_q;
    ack_flags_d = ack_flags_q;
    drop_d      = 1'b0;
    rcv_adv     = rcv_nxt_q;
`ifdef TCP_RX_CSUM_EN
    sum_d       = sum_q;
    idx_d       = idx_q;
`endif

    case (proc_q)
      ST_IDLE: begin
        if (seg_valid && seg_ready_q) begin
          data_d = rx_tcp_data;
`ifdef TCP_RX_CSUM_EN
          proc_d = ST_CHECK;
          sum_d  = 16'h0000;
          idx_d  = '0;
`else
          proc_d = ST_DECIDE;
`endif
        end
      end
`ifdef TCP_RX_CSUM_EN
      ST_CHECK: begin
        // End-around carry folded every word keeps the sum in 16 bits.
        sum_d = w_sum17[15:0] + {15'd0, w_sum17[16]};
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NWORDS - 1)) begin
          proc_d = ST_DECIDE;
        end
      end
`endif
      ST_DECIDE: begin
        proc_d = ST_IDLE;
        if (!w_hdr_ok) begin
          drop_d = 1'b1;
        end else if (w_rst) begin
          conn_d = LISTEN;
        end else begin
          case (conn_q)
            LISTEN: begin
              if (w_syn && !w_ack) begin
                rcv_nxt_d   = w_seq + 32'd1;
                conn_d      = SYN_RCVD;
                ack_valid_d = 1'b1;
                ack_num_d   = w_seq + 32'd1;
                ack_flags_d = 6'h12;
              end else begin
                drop_d = 1'b1;
              end
            end
            SYN_RCVD: begin
              if (w_ack && (w_seq == rcv_nxt_q)) begin
                conn_d = ESTABLISHED;
              end else begin
                drop_d = 1'b1;
              end
            end
            ESTABLISHED: begin
              if (w_seq != rcv_nxt_q) begin
                // Out-of-order: re-advertise what we still expect.
                drop_d      = 1'b1;
                ack_valid_d = 1'b1;
                ack_num_d   = rcv_nxt_q;
                ack_flags_d = 6'h10;
              end else begin
                if (w_psh) begin
                  fix_valid_d = 1'b1;
                  fix_data_d  = data_q[SEG_W-1:160];
                  rcv_adv     = rcv_adv + 32'(PAYLOAD_LEN);
                end
                if (w_fin) begin
                  rcv_adv = rcv_adv + 32'd1;
                  conn_d  = CLOSE_WAIT;
                end
                if (w_psh || w_fin) begin
                  rcv_nxt_d   = rcv_adv;
                  ack_valid_d = 1'b1;
                  ack_num_d   = rcv_adv;
                  ack_flags_d = 6'h10;
                end
              end
            end
            default: begin
              drop_d = 1'b1;
            end
          endcase
        end
      end
      default: begin
        proc_d = ST_IDLE;
      end
    endcase

    // Evaluated after the segment decision so a same-cycle FIN can close.
    if (close_req && (conn_d == CLOSE_WAIT)) begin
      conn_d = LISTEN;
    end
  end

  assign seg_ready_d = (proc_d == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_q      <= ST_IDLE;
      conn_q      <= LISTEN;
      rcv_nxt_q   <= 32'd0;
      data_q      <= '0;
      seg_ready_q <= 1'b0;
      fix_valid_q <= 1'b0;
      fix_data_q  <= '0;
      ack_valid_q <= 1'b0;
      ack_num_q   <= 32'd0;
      ack_flags_q <= 6'd0;
      drop_q      <= 1'b0;
`ifdef TCP_RX_CSUM_EN
      sum_q       <= 16'h0000;
      idx_q       <= '0;
`endif
    end else begin
      proc_q      <= proc_d;
      conn_q      <= conn_d;
      rcv_nxt_q   <= rcv_nxt_d;
      data_q      <= data_d;
      seg_ready_q <= seg_ready_d;
      fix_valid_q <= fix_valid_d;
      fix_data_q  <= fix_data_d;
      ack_valid_q <= ack_valid_d;
      ack_num_q   <= ack_num_d;
      ack_flags_q <= ack_flags_d;
      drop_q      <= drop_d;
`ifdef TCP_RX_CSUM_EN
      sum_q       <= sum_d;
      idx_q       <= idx_d;
`endif
    end
  end

  assign seg_ready  = seg_ready_q;
  assign fix_valid  = fix_valid_q;
  assign fix_data   = fix_data_q;
  assign ack_valid  = ack_valid_q;
  assign ack_num    = ack_num_q;
  assign ack_flags  = ack_flags_q;
  assign conn_state = conn_q;
  assign drop       = drop_q;

endmodule
`default_nettype wire

// File: doc/tcp_rx.md
TCP_RX -- requirements
Module: tcp_rx

Interface
REQ-001 Parameter PAYLOAD_LEN, default 262, FIX payload bytes per segment.
REQ-002 Parameter TCPH_LEN, default 20, TCP header bytes; options unsupported.
REQ-003 Parameter PROTOCOL, default 6, pseudo-header protocol byte.
REQ-004 Parameter SRCADDR, default 32'h7f000001, peer IPv4 address in the pseudo-header.
REQ-005 Parameter DESADDR, default 32'h7f000001, local IPv4 address in the pseudo-header.
REQ-006 Parameter LOCAL_PORT, default 16'd9000, accepted destination port.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 seg_valid  in  1  rx_tcp_data holds a segment.
REQ-010 seg_ready  out  1  block can accept a segment.
REQ-011 rx_tcp_data  in  (PAYLOAD_LEN+TCPH_LEN)*8  segment: [15:0] src port, [31:16] dst port, [63:32] seq, [95:64] ack, [99:96] hdr len, [111:106] flags, [127:112] window, [143:128] checksum, [159:144] urgent ptr, [top:160] payload.
REQ-012 close_req  in  1  application close pulse.
REQ-013 fix_valid  out  1  one-cycle pulse, fix_data valid.
REQ-014 fix_data  out  PAYLOAD_LEN*8  delivered payload.
REQ-015 ack_valid  out  1  one-cycle pulse requesting a reply from the transmitter.
REQ-016 ack_num  out  32  rcv_nxt value for the reply.
REQ-017 ack_flags  out  6  reply flags (FIN=bit0, SYN=1, RST=2, PSH=3, ACK=4, URG=5).
REQ-018 conn_state  out  2  LISTEN=0, SYN_RCVD=1, ESTABLISHED=2, CLOSE_WAIT=3.
REQ-019 drop  out  1  one-cycle pulse, segment discarded.

Function
REQ-020 Handshake: segment captured into an internal register on the edge where seg_valid && seg_ready; seg_ready high only in processing state IDLE.
REQ-021 Processing FSM IDLE -> CHECK -> DECIDE -> IDLE; CHECK sums one 16-bit word per cycle over {pseudo-header, segment}, N=(PAYLOAD_LEN+TCPH_LEN+12)/2 words (147 at default), pseudo-header = {length=TCPH_LEN+PAYLOAD_LEN, PROTOCOL, 8'h0, DESADDR, SRCADDR}.
REQ-022 Sum is 16-bit ones'-complement with end-around carry folded every cycle; checksum OK iff final sum == 16'hFFFF.
REQ-023 Latency: handshake edge k, CHECK edges k+1..k+N, DECIDE edge k+N+1 registers all pulses; seg_ready high from edge k+N+1.
REQ-024 DECIDE drops (drop=1, no other pulse, no state change) on checksum fail, dst port != LOCAL_PORT, or hdr len != TCPH_LEN/4.
REQ-025 RST flag in any state: conn_state -> LISTEN, no ack_valid.
REQ-026 LISTEN + SYN without ACK: rcv_nxt = seq+1, -> SYN_RCVD, ack_valid with ack_flags=6'h12; other segments in LISTEN dropped.
REQ-027 SYN_RCVD + ACK with seq == rcv_nxt: -> ESTABLISHED, no ack_valid; otherwise drop.
REQ-028 ESTABLISHED + PSH, seq == rcv_nxt: fix_valid, fix_data = payload, rcv_nxt += PAYLOAD_LEN, ack_valid flags 6'h10.
REQ-029 ESTABLISHED, seq != rcv_nxt: drop plus duplicate ack_valid with unchanged rcv_nxt, flags 6'h10.
REQ-030 ESTABLISHED + FIN, seq == rcv_nxt: payload delivered first if PSH also set, then rcv_nxt += 1, -> CLOSE_WAIT, ack_valid flags 6'h10.
REQ-031 CLOSE_WAIT: segments other than RST dropped; close_req -> LISTEN next edge; close_req in other states ignored.
REQ-032 rcv_nxt arithmetic is modulo 2^32 (0xFFFFFFFF+1 = 0).
REQ-033 close_req coincident with a DECIDE: segment decision applied first, close_req then evaluated against the resulting state on the same edge.

Reset
REQ-034 rst_n low asynchronously forces: IDLE, conn_state=LISTEN, rcv_nxt=0, sum=0, seg_ready=0 while low and 1 after first edge with rst_n high, fix_valid=ack_valid=drop=0, fix_data=0, ack_num=0, ack_flags=0.
REQ-035 Reset during CHECK abandons the segment with no pulse.

Configuration
REQ-036 Macro TCP_RX_CSUM_EN defined: CHECK state present as REQ-021..REQ-023.
REQ-037 Macro TCP_RX_CSUM_EN undefined: CHECK omitted, checksum treated as OK, DECIDE at edge k+1.

Verification
REQ-038 Valid SYN seq=0x12345678 in LISTEN -> ack_valid, ack_num=0x12345679, ack_flags=0x12, conn_state=1, at edge k+148.
REQ-039 SYN with checksum bit 0 flipped -> drop=1, conn_state stays 0, no ack_valid.
REQ-040 ESTABLISHED rcv_nxt=0xFFFFFF80, PSH seq=0xFFFFFF80 -> fix_valid, payload exact, ack_num=0x00000086.
REQ-041 ESTABLISHED PSH seq=rcv_nxt+262 -> drop=1, no fix_valid, ack_valid with ack_num unchanged.
REQ-042 Segment to dst port 9001 -> drop=1; RST in ESTABLISHED -> conn_state=0.
REQ-043 rst_n low at CHECK word 50 -> all outputs 0, conn_state=0, next SYN processed normally.
